riscv_csr_trap: RTL and testbench

RISCV_CSR_TRAP -- requirements
Module: riscv_csr_trap

---
 rtl/riscv_csr_trap.sv | 185 ++++++++++++++++++
 tb/tb_riscv_csr_trap.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_csr_trap.sv
// riscv_csr_trap: machine-mode CSR file with trap entry and MRET return.
// Handles CSR read/modify/write, illegal/ECALL/EBREAK traps and MRET, and
// produces a registered one-cycle fetch redirect.
// Optional build macro CSR_COUNTERS_EN adds 64-bit mcycle and minstret.
module riscv_csr_trap (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        system_i,
  input  logic        illegal_inst_i,
  input  logic        csr_write_i,
  input  logic        is_mret_i,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [4:0]  zimm_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [31:0] mstatus_val;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  logic        take;
  logic        csr_impl, csr_ro;
  logic [31:0] src, wdata;
  logic        is_op, wr_attempt, csr_illegal;
  logic        is_illegal, is_env;
  logic        trap, do_mret, do_write;
  logic [31:0] cause, tval;

  // An instruction in the redirect cycle is on the wrong path and is dropped.
  assign take = valid_i & ~redirect_o;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};

  // CSR read mux plus implemented/read-only decode of the addressed CSR.
  always_comb begin
    csr_rdata_o = '0;
    csr_impl    = 1'b1;
    csr_ro      = 1'b0;
    case (csr_addr_i)
      A_MSTATUS:   csr_rdata_o = mstatus_val;
      A_MISA:      begin csr_rdata_o = 32'h4000_0100; csr_ro = 1'b1; end
      A_MTVEC:     csr_rdata_o = mtvec;
      A_MSCRATCH:  csr_rdata_o = mscratch;
      A_MEPC:      csr_rdata_o = mepc;
      A_MCAUSE:    csr_rdata_o = mcause;
      A_MTVAL:     csr_rdata_o = mtval;
      A_MHARTID:   csr_rdata_o = '0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:    csr_rdata_o = mcycle[31:0];
      A_MCYCLEH:   csr_rdata_o = mcycle[63:32];
      A_MINSTRET:  csr_rdata_o = minstret[31:0];
      A_MINSTRETH: csr_rdata_o = minstret[63:32];
`endif
      default:     csr_impl = 1'b0;
    endcase
    if (csr_addr_i[11:10] == 2'b11) csr_ro = 1'b1;
  end

  // Write data: RW replaces, RS sets, RC clears; immediate forms use zimm.
  always_comb begin
    src   = funct3_i[2] ? {27'b0, zimm_i} : rs1_data_i;
    wdata = src;
    case (funct3_i[1:0])
      2'b10:   wdata = csr_rdata_o | src;
      2'b11:   wdata = csr_rdata_o & ~src;
      default: wdata = src;
    endcase
  end

  // Set/clear with a zero source is a pure read: no write, no read-only fault.
  // Unimplemented addresses fault even for pure reads.
  assign is_op       = (funct3_i[1:0] != 2'b00);
  assign wr_attempt  = csr_write_i & is_op & ~(funct3_i[1] & (zimm_i == 5'd0));
  assign csr_illegal = csr_write_i & (~csr_impl | (wr_attempt & csr_ro));

  assign is_illegal = illegal_inst_i | csr_illegal;
  assign is_env     = system_i & (funct3_i == 3'b000) & ~is_mret_i;

  assign trap     = take & (is_illegal | is_env);
  assign do_mret  = take & ~is_illegal & ~is_env & is_mret_i;
  assign do_write = take & ~is_illegal & ~is_env & ~is_mret_i & wr_attempt;

  assign cause = is_illegal ? 32'd2 : (inst_i[20] ? 32'd3 : 32'd11);
  assign tval  = is_illegal ? inst_i : 32'd0;

  // Architectural CSR state: trap entry, MRET, then ordinary CSR writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap) begin
      mepc   <= pc_i & 32'hFFFF_FFFC;
      mcause <= cause;
      mtval  <= tval;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (do_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr_i)
        A_MSTATUS:  begin mie <= wdata[3]; mpie <= wdata[7]; end
        A_MTVEC:    mtvec    <= wdata & 32'hFFFF_FFFC;
        A_MSCRATCH: mscratch <= wdata;
        A_MEPC:     mepc     <= wdata & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause   <= wdata;
        A_MTVAL:    mtval    <= wdata;
        default:    ;
      endcase
    end
  end

  // One-cycle redirect pulse to the trap vector or the saved return address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      redirect_o    <= trap | do_mret;
      redirect_pc_o <= trap ? mtvec : (do_mret ? mepc : 32'd0);
    end
  end

`ifdef CSR_COUNTERS_EN
  logic        retire;
  logic [63:0] mcycle_inc, minstret_inc;

  assign retire       = take & ~trap;
  assign mcycle_inc   = mcycle + 64'd1;
  assign minstret_inc = minstret + {63'b0, retire};

  // Counters: a CSR write to either half takes precedence over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (do_write && csr_addr_i == A_MCYCLE)
        mcycle[31:0] <= wdata;
      else if (do_write && csr_addr_i == A_MCYCLEH)
        mcycle <= {wdata, mcycle_inc[31:0]};
      else
        mcycle <= mcycle_inc;

      if (do_write && csr_addr_i == A_MINSTRET)
        minstret[31:0] <= wdata;
      else if (do_write && csr_addr_i == A_MINSTRETH)
        minstret <= {wdata, minstret_inc[31:0]};
      else
        minstret <= minstret_inc;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_csr_trap.sv
// Directed bench for riscv_csr_trap with a scoreboard queue of expectations.
module tb_riscv_csr_trap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, system_i, illegal_inst_i, csr_write_i, is_mret_i;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  zimm_i;
  logic [31:0] rs1_data_i, pc_i, inst_i;
  logic [31:0] csr_rdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rdata_s;

  riscv_csr_trap dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .system_i(system_i),
    .illegal_inst_i(illegal_inst_i), .csr_write_i(csr_write_i),
    .is_mret_i(is_mret_i), .funct3_i(funct3_i), .csr_addr_i(csr_addr_i),
    .zimm_i(zimm_i), .rs1_data_i(rs1_data_i), .pc_i(pc_i), .inst_i(inst_i),
    .csr_rdata_o(csr_rdata_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic clear_in();
    valid_i = 0; system_i = 0; illegal_inst_i = 0; csr_write_i = 0;
    is_mret_i = 0; funct3_i = 0; csr_addr_i = 0; zimm_i = 0;
    rs1_data_i = 0; pc_i = 0; inst_i = 0;
  endtask

  // Presents one instruction for one cycle; called at a negedge, returns at the next.
  task automatic drive(input logic sys, ill, cw, mr, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [4:0] zi,
                       input logic [31:0] rs1, pc, inst);
    valid_i = 1; system_i = sys; illegal_inst_i = ill; csr_write_i = cw;
    is_mret_i = mr; funct3_i = f3; csr_addr_i = addr; zimm_i = zi;
    rs1_data_i = rs1; pc_i = pc; inst_i = inst;
    #1 rdata_s = csr_rdata_o;
    @(negedge clk);
    clear_in();
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] addr,
                     input logic [4:0] zi, input logic [31:0] rs1, pc);
    drive(1, 0, 1, 0, f3, addr, zi, rs1, pc, {addr, zi, f3, 5'd0, 7'h73});
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    push(tag, exp);
    csr_addr_i = addr;
    #1 chk(csr_rdata_o);
    @(negedge clk);
  endtask

  task automatic exp_redir(input string tag, input logic [31:0] pc);
    push({tag, "_redir"}, 32'd1);
    chk({31'd0, redirect_o});
    push({tag, "_redir_pc"}, pc);
    chk(redirect_pc_o);
  endtask

  initial begin
    clear_in();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    push("rst_redir", 32'd0);    chk({31'd0, redirect_o});
    push("rst_redir_pc", 32'd0); chk(redirect_pc_o);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rst_n = 1;
    @(negedge clk);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("rst_mtvec", 12'h305, 32'd0);
    rd("mhartid", 12'hF14, 32'd0);
    rd("unimpl_read", 12'h123, 32'd0);

    // mscratch RW, then pure-read RS with zimm=0, then RCI / RSI
    csr(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 32'h10);
    csr(3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'h14);
    push("rs_zero_rdata", 32'hDEAD_BEEF); chk(rdata_s);
    push("rs_zero_no_redir", 32'd0);      chk({31'd0, redirect_o});
    rd("mscratch_kept", 12'h340, 32'hDEAD_BEEF);
    csr(3'b111, 12'h340, 5'h0F, 32'd0, 32'h18);
    rd("rci", 12'h340, 32'hDEAD_BEE0);
    csr(3'b110, 12'h340, 5'h10, 32'd0, 32'h1C);
    rd("rsi", 12'h340, 32'hDEAD_BEF0);

    // ECALL with MIE set
    csr(3'b001, 12'h305, 5'd1, 32'h0000_0103, 32'h20);
    rd("mtvec_mask", 12'h305, 32'h0000_0100);
    csr(3'b110, 12'h300, 5'd8, 32'd0, 32'h24);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    drive(1, 0, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0, 32'h80, 32'h0000_0073);
    exp_redir("ecall", 32'h100);
    rd("mepc_ecall", 12'h341, 32'h80);
    push("redir_pulse", 32'd0); chk({31'd0, redirect_o});
    rd("mcause_ecall", 12'h342, 32'd11);
    rd("mtval_ecall", 12'h343, 32'd0);
    rd("mstatus_ecall", 12'h300, 32'h0000_1880);

    // MRET
    drive(1, 0, 0, 1, 3'b000, 12'h302, 5'd0, 32'd0, 32'h104, 32'h3020_0073);
    exp_redir("mret", 32'h80);
    rd("mstatus_mret", 12'h300, 32'h0000_1888);

    // write to read-only mhartid
    csr(3'b001, 12'hF14, 5'd1, 32'd5, 32'h40);
    exp_redir("ro_write", 32'h100);
    rd("mcause_ro", 12'h342, 32'd2);
    rd("mtval_ro", 12'h343, 32'hF140_9073);
    rd("mepc_ro", 12'h341, 32'h40);
    rd("mhartid_kept", 12'hF14, 32'd0);
    rd("mstatus_ro", 12'h300, 32'h0000_1880);

    // EBREAK, and illegal taking priority over ECALL
    drive(1, 0, 0, 0, 3'b000, 12'h001, 5'd0, 32'd0, 32'h44, 32'h0010_0073);
    exp_redir("ebreak", 32'h100);
    rd("mcause_ebreak", 12'h342, 32'd3);
    rd("mtval_ebreak", 12'h343, 32'd0);
    drive(1, 1, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0, 32'h48, 32'h0000_0073);
    exp_redir("illegal", 32'h100);
    rd("mcause_illegal", 12'h342, 32'd2);
    rd("mtval_illegal", 12'h343, 32'h0000_0073);

    // instruction in the redirect cycle is squashed
`ifdef CSR_COUNTERS_EN
    csr(3'b001, 12'hB02, 5'd1, 32'd0, 32'h4C);
`endif
    drive(1, 0, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0, 32'h50, 32'h0000_0073);
    exp_redir("squash_ecall", 32'h100);
    csr(3'b001, 12'h340, 5'd1, 32'h1234_5678, 32'h54);
    push("squash_no_redir", 32'd0); chk({31'd0, redirect_o});
    rd("mscratch_squash", 12'h340, 32'hDEAD_BEF0);
    rd("mepc_squash", 12'h341, 32'h50);
`ifdef CSR_COUNTERS_EN
    rd("minstret_squash", 12'hB02, 32'd0);
    csr(3'b010, 12'h340, 5'd0, 32'd0, 32'h58);
    rd("minstret_one", 12'hB02, 32'd1);

    // mcycle carry into high half
    csr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'h5C);
    rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_carry", 12'hB80, 32'd1);
    rd("mcycle_wrapped", 12'hB00, 32'd1);
`else
    csr(3'b010, 12'hB00, 5'd0, 32'd0, 32'h5C);
    push("mcycle_unimpl_rdata", 32'd0); chk(rdata_s);
    exp_redir("mcycle_unimpl", 32'h100);
    rd("mcause_mcycle", 12'h342, 32'd2);
    rd("mtval_mcycle", 12'h343, 32'hB000_2073);
`endif

    // reset while a redirect is pending
    drive(1, 0, 0, 0, 3'b000, 12'h000, 5'd0, 32'd0, 32'h60, 32'h0000_0073);
    exp_redir("pre_reset", 32'h100);
    rst_n = 0;
    #1;
    push("reset_cancel", 32'd0);    chk({31'd0, redirect_o});
    push("reset_cancel_pc", 32'd0); chk(redirect_pc_o);
    rd("reset_mstatus", 12'h300, 32'h0000_1800);
    rd("reset_mscratch", 12'h340, 32'd0);
    rst_n = 1;
    @(negedge clk);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
